// File: rtl/bnn_acc_array_if.sv
// Control, beat and result bus of the multi-lane +/-1 accumulator array.
interface bnn_acc_array_if #(
  parameter int unsigned N     = 12,
  parameter int unsigned LANES = 8,
  parameter int unsigned CNT_W = 8
);
  logic               start;
  logic [CNT_W-1:0]   len;
  logic [N-1:0]       bias;
  logic               in_valid;
  logic               in_ready;
  logic [LANES-1:0]   in_bits;
  logic               in_op;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*N-1:0] out_data;
  logic [LANES-1:0]   sat_flag;
  logic               busy;

  modport master (
    output start, len, bias, in_valid, in_bits, in_op, out_ready,
    input  in_ready, out_valid, out_data, sat_flag, busy
  );

  modport slave (
    input  start, len, bias, in_valid, in_bits, in_op, out_ready,
    output in_ready, out_valid, out_data, sat_flag, busy
  );
endinterface

// File: rtl/bnn_acc_array.sv
// LANES saturating signed accumulators, bias-preloaded, each stepping +/-1 per set
// lane bit over a len-beat run; result held on a valid/ready port.
module bnn_acc_array #(
  parameter int unsigned N     = 12,
  parameter int unsigned LANES = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  bnn_acc_array_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  localparam logic signed [N:0] MAX_V = {2'b00, {(N-1){1'b1}}};
  localparam logic signed [N:0] MIN_V = {2'b11, {(N-1){1'b0}}};

  state_e               state_q, state_d;
  logic signed [N-1:0]  acc_q [LANES];
  logic signed [N-1:0]  acc_d [LANES];
  logic [LANES-1:0]     sat_q, sat_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 in_ready_q, out_valid_q, busy_q;
  logic signed [N:0]    sum;

  // Next-state and per-lane accumulate with clamp in N+1 bits
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    sum     = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int unsigned i = 0; i < LANES; i++) acc_d[i] = $signed(bus.bias);
          sat_d   = '0;
          cnt_d   = bus.len;
          state_d = (bus.len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (bus.in_valid && in_ready_q) begin
          cnt_d = cnt_q - CNT_W'(1);
          for (int unsigned i = 0; i < LANES; i++) begin
            if (bus.in_bits[i]) begin
              sum = bus.in_op ? ($signed({acc_q[i][N-1], acc_q[i]}) - (N+1)'(1))
                              : ($signed({acc_q[i][N-1], acc_q[i]}) + (N+1)'(1));
              if (sum > MAX_V) begin
                acc_d[i] = MAX_V[N-1:0];
                sat_d[i] = 1'b1;
              end else if (sum < MIN_V) begin
                acc_d[i] = MIN_V[N-1:0];
                sat_d[i] = 1'b1;
              end else begin
                acc_d[i] = sum[N-1:0];
              end
            end
          end
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < LANES; i++) acc_q[i] <= '0;
      sat_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == ACCUM);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign bus.out_data[g*N +: N] = acc_q[g];
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat_flag  = sat_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bnn_acc_array.sv
// Scoreboard bench for bnn_acc_array: directed runs plus randomized runs with stalls.
module tb_bnn_acc_array;
  localparam int unsigned N     = 12;
  localparam int unsigned LANES = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DW    = N * LANES;

  typedef struct {
    logic [DW-1:0]    data;
    logic [LANES-1:0] sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 1;
  exp_t sb [$];
  logic [LANES-1:0] bits_a [256];
  logic             op_a   [256];

  bnn_acc_array_if #(.N(N), .LANES(LANES), .CNT_W(CNT_W)) bus ();

  bnn_acc_array #(.N(N), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // out_ready: 0 = held low, 1 = held high, 2 = random
  always @(posedge clk) begin
    #2;
    bus.out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  // Scoreboard pop on every output handshake
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", DW'(1), DW'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", bus.out_data, e.data);
        check("sat_flag", DW'(bus.sat_flag), DW'(e.sat));
      end
    end
  end

  task automatic run(input int bias, input int len, input int gap_pct, input bit poke,
                     input int want_lat, input int hold);
    int v [LANES];
    exp_t e;
    int t0, to, saved;
    bit got;
    e.sat = '0;
    for (int i = 0; i < int'(LANES); i++) v[i] = bias;
    for (int b = 0; b < len; b++)
      for (int i = 0; i < int'(LANES); i++)
        if (bits_a[b][i]) begin
          v[i] = op_a[b] ? v[i] - 1 : v[i] + 1;
          if (v[i] > 2047)  begin v[i] = 2047;  e.sat[i] = 1'b1; end
          if (v[i] < -2048) begin v[i] = -2048; e.sat[i] = 1'b1; end
        end
    for (int i = 0; i < int'(LANES); i++) e.data[i*N +: N] = N'(v[i]);
    sb.push_back(e);
    saved = rdy_mode;
    if (hold > 0) rdy_mode = 0;

    bus.start = 1'b1;
    bus.len   = CNT_W'(len);
    bus.bias  = N'(bias);
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = CNT_W'($urandom);
    bus.bias  = N'($urandom);
    for (int b = 0; b < len; b++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_bits  = LANES'($urandom);
        bus.in_op    = 1'($urandom);
        if (poke) begin
          bus.start = 1'b1;
          bus.len   = CNT_W'(3);
          bus.bias  = N'(100);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      bus.in_valid = 1'b1;
      bus.in_bits  = bits_a[b];
      bus.in_op    = op_a[b];
      to = 0;
      do begin
        got = bus.in_ready;
        @(posedge clk); #1;
        to++;
      end while (!got && to < 100);
      if (!got) check("in_ready_timeout", DW'(0), DW'(1));
    end
    bus.in_valid = 1'b0;

    to = 0;
    while (!bus.out_valid && to < 100) begin
      @(posedge clk); #1;
      to++;
    end
    check("out_valid_seen", DW'(bus.out_valid), DW'(1));
    if (want_lat >= 0) check("latency", DW'(cyc - t0), DW'(want_lat));
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", DW'(bus.out_valid), DW'(1));
      check("hold_data", bus.out_data, e.data);
      @(posedge clk); #1;
    end
    rdy_mode = saved;
    to = 0;
    while (bus.busy && to < 1000) begin
      @(posedge clk); #1;
      to++;
    end
    check("return_idle", DW'(bus.busy), DW'(0));
  endtask

  task automatic fill(input int len, input logic op, input logic [LANES-1:0] bits);
    for (int b = 0; b < len; b++) begin
      op_a[b]   = op;
      bits_a[b] = bits;
    end
  endtask

  initial begin
    int bias, len;
    logic dir;
    bus.start = 1'b0; bus.len = '0; bus.bias = '0;
    bus.in_valid = 1'b0; bus.in_bits = '0; bus.in_op = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data", bus.out_data, DW'(0));
    check("rst_sat", DW'(bus.sat_flag), DW'(0));
    check("rst_in_ready", DW'(bus.in_ready), DW'(0));
    check("rst_out_valid", DW'(bus.out_valid), DW'(0));
    check("rst_busy", DW'(bus.busy), DW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All lanes count up from zero, zero-stall latency
    fill(4, 1'b0, 8'hFF);
    run(0, 4, 0, 1'b0, 5, 0);

    op_a[0] = 1'b0; bits_a[0] = 8'h01;
    op_a[1] = 1'b1; bits_a[1] = 8'h03;
    op_a[2] = 1'b1; bits_a[2] = 8'h02;
    run(-3, 3, 0, 1'b0, 4, 0);

    // Saturation at both ends
    fill(5, 1'b0, 8'h01);
    run(2045, 5, 0, 1'b0, 6, 0);
    fill(5, 1'b1, 8'h01);
    run(-2046, 5, 0, 1'b0, 6, 0);

    // Zero-length run with long backpressure
    run(7, 0, 0, 1'b0, 1, 10);

    // Gapped input with start pulses that must be ignored
    fill(12, 1'b0, 8'hA5);
    op_a[3] = 1'b1; op_a[7] = 1'b1;
    run(-10, 12, 50, 1'b1, -1, 0);

    // Reset mid-run discards everything
    bus.start = 1'b1; bus.len = CNT_W'(10); bus.bias = N'(50);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_bits = 8'hFF; bus.in_op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_data", bus.out_data, DW'(0));
    check("midrst_sat", DW'(bus.sat_flag), DW'(0));
    check("midrst_busy", DW'(bus.busy), DW'(0));
    check("midrst_in_ready", DW'(bus.in_ready), DW'(0));
    check("midrst_out_valid", DW'(bus.out_valid), DW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill(2, 1'b1, 8'h0F);
    run(1, 2, 0, 1'b0, 3, 0);

    // Randomized runs with stalls on both sides, biased toward the saturation edges
    rdy_mode = 2;
    for (int r = 0; r < 400; r++) begin
      case ($urandom_range(0, 3))
        0:       bias = 2047 - int'($urandom_range(0, 6));
        1:       bias = -2048 + int'($urandom_range(0, 6));
        default: bias = int'($urandom_range(0, 4095)) - 2048;
      endcase
      len = int'($urandom_range(0, 30));
      dir = 1'($urandom);
      for (int b = 0; b < len; b++) begin
        op_a[b]   = ($urandom_range(0, 9) < 8) ? dir : ~dir;
        bits_a[b] = LANES'($urandom);
      end
      run(bias, len, int'($urandom_range(0, 40)), 1'($urandom), -1, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", DW'(sb.size()), DW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
